// File: rtl/lc3b_types.sv
// Shared LC-3b bus types and the L2 controller state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_burst;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } lc3b_l2_state;

endpackage

// File: rtl/cache_l2_way.sv
// One way of the set-associative L2: line data, tags, and per-set valid/dirty bits.
module cache_l2_way
    import lc3b_types::*;
#(
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 12 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic [TAG_W-1:0] tag,
    input  lc3b_burst        wdata,
    input  logic             load,
    input  logic             fill,
    output logic             hit,
    output lc3b_burst        data,
    output logic [TAG_W-1:0] line_tag,
    output logic             valid,
    output logic             dirty
);

    lc3b_burst        data_arr [SETS];
    logic [TAG_W-1:0] tag_arr  [SETS];
    logic [SETS-1:0]  valid_vec;
    logic [SETS-1:0]  dirty_vec;

    // Line storage carries no reset; validity alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (load || fill) begin
            data_arr[index] <= wdata;
        end
        if (fill) begin
            tag_arr[index] <= tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_vec <= '0;
            dirty_vec <= '0;
        end else if (fill) begin
            valid_vec[index] <= 1'b1;
            dirty_vec[index] <= 1'b0;
        end else if (load) begin
            dirty_vec[index] <= 1'b1;
        end
    end

    assign data     = data_arr[index];
    assign line_tag = tag_arr[index];
    assign valid    = valid_vec[index];
    assign dirty    = dirty_vec[index];
    assign hit      = valid_vec[index] && (tag_arr[index] == tag);

endmodule

// File: rtl/cache_l2_assoc.sv
// Set-associative write-back, write-allocate L2 cache with invalid-first,
// round-robin replacement and saturating hit/miss counters.
module cache_l2_assoc
    import lc3b_types::*;
#(
    parameter int SETS      = 8,
    parameter int WAYS      = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  lc3b_word             mem_address,
    input  lc3b_burst            mem_wdata,
    output logic                 mem_resp,
    output lc3b_burst            mem_rdata,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output lc3b_word             pmem_address,
    output lc3b_burst            pmem_wdata,
    input  logic                 pmem_resp,
    input  lc3b_burst            pmem_rdata,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 12 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    lc3b_l2_state     state, state_next;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             req;

    logic [WAYS-1:0]  hit_v, valid_v, dirty_v, load_v, fill_v;
    lc3b_burst        way_data [WAYS];
    logic [TAG_W-1:0] way_tag  [WAYS];
    lc3b_burst        way_wdata;

    logic [WAY_W-1:0] ptr [SETS];
    logic [WAY_W-1:0] victim, pick, hit_way;
    logic             victim_from_ptr, inv_found, hit_any;
    logic             missed, miss_start;

    assign index     = mem_address[4+IDX_W-1:4];
    assign tag       = mem_address[15:4+IDX_W];
    assign req       = mem_read || mem_write;
    assign way_wdata = (state == FILL) ? pmem_rdata : mem_wdata;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_l2_way #(
            .SETS  (SETS),
            .IDX_W (IDX_W),
            .TAG_W (TAG_W)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .index    (index),
            .tag      (tag),
            .wdata    (way_wdata),
            .load     (load_v[w]),
            .fill     (fill_v[w]),
            .hit      (hit_v[w]),
            .data     (way_data[w]),
            .line_tag (way_tag[w]),
            .valid    (valid_v[w]),
            .dirty    (dirty_v[w])
        );
    end

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_v[w]) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest-numbered invalid way wins; only a full set falls back to the pointer.
    always_comb begin
        inv_found = 1'b0;
        pick      = ptr[index];
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_v[w] && !inv_found) begin
                inv_found = 1'b1;
                pick      = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        load_v       = '0;
        fill_v       = '0;
        miss_start   = 1'b0;
        case (state)
            IDLE: begin
                if (req && hit_any) begin
                    mem_resp  = 1'b1;
                    mem_rdata = way_data[hit_way];
                    if (mem_write) begin
                        load_v[hit_way] = 1'b1;
                    end
                end else if (req) begin
                    miss_start = 1'b1;
                    state_next = (valid_v[pick] && dirty_v[pick]) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {way_tag[victim], index, 4'h0};
                pmem_wdata   = way_data[victim];
                if (pmem_resp) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {tag, index, 4'h0};
                if (pmem_resp) begin
                    fill_v[victim] = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            victim          <= '0;
            victim_from_ptr <= 1'b0;
            missed          <= 1'b0;
            hit_count       <= '0;
            miss_count      <= '0;
            for (int s = 0; s < SETS; s++) begin
                ptr[s] <= '0;
            end
        end else begin
            state <= state_next;
            if (miss_start) begin
                victim          <= pick;
                victim_from_ptr <= !inv_found;
                missed          <= 1'b1;
                if (miss_count != '1) begin
                    miss_count <= miss_count + 1'b1;
                end
            end
            // A response that follows a fill is the tail of a miss, not a hit.
            if (mem_resp) begin
                missed <= 1'b0;
                if (!missed && hit_count != '1) begin
                    hit_count <= hit_count + 1'b1;
                end
            end
            if (state == FILL && pmem_resp && victim_from_ptr) begin
                ptr[index] <= (ptr[index] == WAY_W'(WAYS - 1)) ? '0 : ptr[index] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_l2_assoc.sv
// Directed bench for cache_l2_assoc: vector table for hit traffic, sequences for misses and reset.
module tb_cache_l2_assoc;
    import lc3b_types::*;

    logic        clk;
    logic        rst;
    logic        mem_read, mem_write;
    lc3b_word    mem_address;
    lc3b_burst   mem_wdata;
    logic        pmem_resp;
    lc3b_burst   pmem_rdata;

    logic        mem_resp, pmem_read, pmem_write;
    lc3b_burst   mem_rdata, pmem_wdata;
    lc3b_word    pmem_address;
    logic [15:0] hit_count, miss_count;

    logic        mem_resp2, pmem_read2, pmem_write2;
    lc3b_burst   mem_rdata2, pmem_wdata2;
    lc3b_word    pmem_address2;
    logic [1:0]  hit_count2, miss_count2;

    int total = 0;
    int bad   = 0;

    localparam lc3b_burst D0 = 128'hD0D0_0000_1111_2222_3333_4444_5555_0000;
    localparam lc3b_burst D1 = 128'hD1D1_1111_AAAA_BBBB_CCCC_DDDD_EEEE_0001;
    localparam lc3b_burst D2 = 128'hD2D2_2222_0123_4567_89AB_CDEF_0F0F_0002;
    localparam lc3b_burst D3 = 128'hD3D3_3333_FEDC_BA98_7654_3210_F0F0_0003;
    localparam lc3b_burst D4 = 128'hD4D4_4444_5A5A_A5A5_5A5A_A5A5_1234_0004;
    localparam lc3b_burst D5 = 128'hD5D5_5555_DEAD_BEEF_CAFE_F00D_9876_0005;
    localparam lc3b_burst D6 = 128'hD6D6_6666_0000_FFFF_0000_FFFF_4321_0006;
    localparam lc3b_burst D7 = 128'hD7D7_7777_1357_9BDF_2468_ACE0_ABCD_0007;

    cache_l2_assoc #(.SETS(8), .WAYS(2), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_l2_assoc #(.SETS(8), .WAYS(2), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp2), .mem_rdata(mem_rdata2),
        .pmem_read(pmem_read2), .pmem_write(pmem_write2),
        .pmem_address(pmem_address2), .pmem_wdata(pmem_wdata2),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .hit_count(hit_count2), .miss_count(miss_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        lc3b_burst   wdata;
        bit          chk_rd;
        lc3b_burst   exp_rdata;
        int          exp_hit;
        int          exp_miss;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int sat2(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic chk_cnt(input string nm, input int eh, input int em);
        chk({nm, " hit_count"},  128'(hit_count),  128'(eh));
        chk({nm, " miss_count"}, 128'(miss_count), 128'(em));
        chk({nm, " sat hit_count"},  128'(hit_count2),  128'(sat2(eh)));
        chk({nm, " sat miss_count"}, 128'(miss_count2), 128'(sat2(em)));
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        pmem_resp   = 1'b0;
        pmem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset mem_resp", 128'(mem_resp), 128'(0));
        chk("reset pmem_rw", 128'({pmem_read, pmem_write}), 128'(0));
        chk("reset pmem_address", 128'(pmem_address), 128'(0));
        chk("reset mem_rdata", mem_rdata, 128'(0));
        chk_cnt("reset", 0, 0);
    endtask

    task automatic apply_vec(input int i);
        vec_t v;
        v = vecs[i];
        mem_read    = v.rd;
        mem_write   = v.wr;
        mem_address = v.addr;
        mem_wdata   = v.wdata;
        @(negedge clk);
        chk($sformatf("vec%0d mem_resp", i), 128'(mem_resp), 128'(1));
        if (v.chk_rd) begin
            chk($sformatf("vec%0d mem_rdata", i), mem_rdata, v.exp_rdata);
        end
        chk($sformatf("vec%0d pmem idle", i), 128'({pmem_read, pmem_write}), 128'(0));
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk_cnt($sformatf("vec%0d", i), v.exp_hit, v.exp_miss);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            apply_vec(i);
        end
    endtask

    task automatic miss_seq(input string nm, input bit rd, input bit wr, input logic [15:0] addr,
                            input lc3b_burst wd, input bit wb, input logic [15:0] wb_addr,
                            input lc3b_burst wb_data, input lc3b_burst fill, input int eh, input int em);
        int n;
        mem_read    = rd;
        mem_write   = wr;
        mem_address = addr;
        mem_wdata   = wd;
        @(negedge clk);
        chk({nm, " no resp on miss"}, 128'(mem_resp), 128'(0));
        chk({nm, " pmem idle on miss"}, 128'({pmem_read, pmem_write}), 128'(0));
        @(negedge clk);
        if (wb) begin
            chk({nm, " wb pmem_write"}, 128'(pmem_write), 128'(1));
            chk({nm, " wb pmem_read"}, 128'(pmem_read), 128'(0));
            chk({nm, " wb pmem_address"}, 128'(pmem_address), 128'(wb_addr));
            chk({nm, " wb pmem_wdata"}, pmem_wdata, wb_data);
            pmem_resp = 1'b1;
            @(posedge clk);
            #1 pmem_resp = 1'b0;
            @(negedge clk);
        end else begin
            chk({nm, " no writeback"}, 128'(pmem_write), 128'(0));
        end
        n = 0;
        while (!pmem_read && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (!wb) begin
            chk({nm, " fill latency"}, 128'(n), 128'(0));
        end
        chk({nm, " fill pmem_read"}, 128'(pmem_read), 128'(1));
        chk({nm, " fill pmem_address"}, 128'(pmem_address), 128'({addr[15:4], 4'h0}));
        chk({nm, " fill no resp"}, 128'(mem_resp), 128'(0));
        pmem_rdata = fill;
        pmem_resp  = 1'b1;
        @(posedge clk);
        #1 pmem_resp = 1'b0;
        @(negedge clk);
        chk({nm, " done mem_resp"}, 128'(mem_resp), 128'(1));
        chk({nm, " done pmem idle"}, 128'({pmem_read, pmem_write}), 128'(0));
        if (rd && !wr) begin
            chk({nm, " done mem_rdata"}, mem_rdata, fill);
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk_cnt(nm, eh, em);
    endtask

    initial begin
        vecs[0]  = '{rd: 1'b0, wr: 1'b1, addr: 16'h1230, wdata: D1, chk_rd: 1'b0, exp_rdata: '0, exp_hit: 1, exp_miss: 1};
        vecs[1]  = '{rd: 1'b1, wr: 1'b0, addr: 16'h1230, wdata: '0, chk_rd: 1'b1, exp_rdata: D1, exp_hit: 2, exp_miss: 1};
        vecs[2]  = '{rd: 1'b1, wr: 1'b0, addr: 16'h12B0, wdata: '0, chk_rd: 1'b1, exp_rdata: D3, exp_hit: 3, exp_miss: 3};
        vecs[3]  = '{rd: 1'b1, wr: 1'b0, addr: 16'h1330, wdata: '0, chk_rd: 1'b1, exp_rdata: D4, exp_hit: 4, exp_miss: 3};
        vecs[4]  = '{rd: 1'b0, wr: 1'b1, addr: 16'h1330, wdata: D5, chk_rd: 1'b0, exp_rdata: '0, exp_hit: 5, exp_miss: 3};
        vecs[5]  = '{rd: 1'b1, wr: 1'b1, addr: 16'h1230, wdata: D2, chk_rd: 1'b0, exp_rdata: '0, exp_hit: 6, exp_miss: 5};
        vecs[6]  = '{rd: 1'b1, wr: 1'b0, addr: 16'h1230, wdata: '0, chk_rd: 1'b1, exp_rdata: D2, exp_hit: 7, exp_miss: 5};
        vecs[7]  = '{rd: 1'b1, wr: 1'b0, addr: 16'h12B0, wdata: '0, chk_rd: 1'b1, exp_rdata: D7, exp_hit: 8, exp_miss: 5};
        for (int i = 0; i < 5; i++) begin
            vecs[8+i] = '{rd: 1'b1, wr: 1'b0, addr: 16'h1238, wdata: '0, chk_rd: 1'b1, exp_rdata: D0,
                          exp_hit: i + 1, exp_miss: 1};
        end
        vecs[13] = '{rd: 1'b1, wr: 1'b0, addr: 16'h1230, wdata: '0, chk_rd: 1'b1, exp_rdata: D1, exp_hit: 1, exp_miss: 1};

        do_reset();

        miss_seq("rd1230", 1'b1, 1'b0, 16'h1230, '0, 1'b0, '0, '0, D0, 0, 1);
        run_vecs(0, 1);
        miss_seq("rd12B0", 1'b1, 1'b0, 16'h12B0, '0, 1'b0, '0, '0, D3, 2, 2);
        miss_seq("rd1330", 1'b1, 1'b0, 16'h1330, '0, 1'b1, 16'h1230, D1, D4, 2, 3);
        run_vecs(2, 4);
        // Pointer now selects way1 (clean 0x12B0), then way0 (dirty 0x1330).
        miss_seq("rd1230b", 1'b1, 1'b0, 16'h1230, '0, 1'b0, '0, '0, D6, 5, 4);
        miss_seq("rd12B0b", 1'b1, 1'b0, 16'h12B0, '0, 1'b1, 16'h1330, D5, D7, 5, 5);
        run_vecs(5, 7);

        do_reset();
        miss_seq("sat miss", 1'b1, 1'b0, 16'h1230, '0, 1'b0, '0, '0, D0, 0, 1);
        run_vecs(8, 12);

        do_reset();
        mem_read    = 1'b1;
        mem_write   = 1'b0;
        mem_address = 16'h1230;
        @(negedge clk);
        chk("midfill miss no resp", 128'(mem_resp), 128'(0));
        @(negedge clk);
        chk("midfill pmem_read", 128'(pmem_read), 128'(1));
        #1 rst = 1'b1;
        #1;
        chk("midfill rst pmem_read", 128'(pmem_read), 128'(0));
        chk("midfill rst pmem_address", 128'(pmem_address), 128'(0));
        chk("midfill rst miss_count", 128'(miss_count), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        miss_seq("refill", 1'b1, 1'b0, 16'h1230, '0, 1'b0, '0, '0, D1, 0, 1);
        run_vecs(13, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
